// File: rtl/elbeth_mem_responder_if.sv
// Request/response bus between an initiator and the elbeth memory responder.
interface elbeth_mem_responder_if;
  logic        en;
  logic [31:0] addr;
  logic [3:0]  rw;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        error;

  modport master (output en, addr, rw, wdata, input rdata, ready, error);
  modport slave  (input en, addr, rw, wdata, output rdata, ready, error);
endinterface

// File: rtl/elbeth_mem_responder.sv
// Single-port RAM responder with programmable wait states, byte-lane writes,
// alignment/range fault detection and abort on request withdrawal.
module elbeth_mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  elbeth_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        capture;
  logic [31:0] addr_q, wdata_q, rdata_hold, rdata_resp, word_idx;
  logic [3:0]  rw_q;
  logic        fault;
  logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en) begin
          capture    = 1'b1;
          cnt_next   = 4'(WAIT_CYCLES);
          state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        // Withdrawn request abandons the transaction before any side effect.
        if (!bus.en) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - 4'd1;
          if (cnt == 4'd1) state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    word_idx   = (addr_q - BASE_ADDR) >> 2;
    fault      = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                 ((word_idx >> DEPTH_LOG2) != '0);
    rdata_resp = fault ? '0 : mem[word_idx[DEPTH_LOG2-1:0]];
    bus.ready  = (state == RESP);
    bus.error  = (state == RESP) && fault;
    // Response data is live only in RESP; otherwise the last response is replayed.
    bus.rdata  = (state == RESP) ? rdata_resp : rdata_hold;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      rw_q       <= '0;
      wdata_q    <= '0;
      rdata_hold <= '0;
    end else begin
      if (capture) begin
        addr_q  <= bus.addr;
        rw_q    <= bus.rw;
        wdata_q <= bus.wdata;
      end
      if (state == RESP) rdata_hold <= rdata_resp;
    end
  end

  always_ff @(posedge clk) begin
    if (state == RESP && !fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (rw_q[i]) mem[word_idx[DEPTH_LOG2-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
